// File: rtl/ext_mem_loader_pkg.sv
// Shared definitions for the external memory loader: FSM encoding and word geometry.
package ext_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int COUNT_W    = 9;

endpackage

// File: rtl/ext_mem_loader.sv
// Streams host words into CPU external memory while holding the core in reset.
// Optional checksum accumulator enabled by defining LOADER_CHECKSUM_EN.
module ext_mem_loader
    import ext_mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  word_count,
    output logic [31:0] checksum
);

    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_WORDS);
    localparam logic [31:0]        ADR_STEP = 32'(WORD_BYTES);

    state_t             r_state;
    state_t             w_nextState;
    logic [31:0]        r_adr;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [31:0]        r_wadr;
    logic [COUNT_W-1:0] r_count;
    logic               r_relCnt;

    logic               w_inReady;
    logic               w_cpuReset;
    logic               w_busy;
    logic               w_done;
    logic               w_error;
    logic               w_accept;
    logic               w_startLoad;
    logic [COUNT_W-1:0] w_countNext;

    assign w_accept    = in_valid && w_inReady;
    assign w_countNext = (r_count == {COUNT_W{1'b1}}) ? r_count : r_count + 1'b1;
    assign w_startLoad = (w_nextState == ST_LOAD) && (r_state != ST_LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_cpuReset  = 1'b1;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_nextState = ST_LOAD;
            end
            ST_LOAD: begin
                w_inReady = 1'b1;
                w_busy    = 1'b1;
                // A last word always wins over the overflow check.
                if (in_valid) begin
                    if (in_last)                     w_nextState = ST_FLUSH;
                    else if (w_countNext == MAX_CNT) w_nextState = ST_ERR;
                end
            end
            ST_FLUSH: begin
                w_busy      = 1'b1;
                w_nextState = ST_RELEASE;
            end
            ST_RELEASE: begin
                w_busy = 1'b1;
                if (r_relCnt) w_nextState = ST_DONE;
            end
            ST_DONE: begin
                w_cpuReset = 1'b0;
                w_done     = 1'b1;
                if (start) w_nextState = ST_LOAD;
            end
            ST_ERR: begin
                w_error = 1'b1;
                if (start) w_nextState = ST_LOAD;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Write port is registered, so an async reset drops any write still pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adr    <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_wadr   <= '0;
            r_count  <= '0;
            r_relCnt <= 1'b0;
        end else begin
            r_we     <= w_accept;
            r_relCnt <= (r_state == ST_RELEASE) ? ~r_relCnt : 1'b0;
            if (w_accept) begin
                r_wdata <= in_data;
                r_wadr  <= r_adr;
                r_adr   <= r_adr + ADR_STEP;
                r_count <= w_countNext;
            end
            if (w_startLoad) begin
                r_adr   <= BASE_ADR;
                r_count <= '0;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if (w_startLoad) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign in_ready      = w_inReady;
    assign Ext_MemWrite  = r_we;
    assign Ext_WriteData = r_wdata;
    assign Ext_DataAdr   = r_wadr;
    assign cpu_reset     = w_cpuReset;
    assign busy          = w_busy;
    assign done          = w_done;
    assign error         = w_error;
    assign word_count    = r_count;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Self-checking bench for ext_mem_loader: three instances (default, MAX_WORDS=4,
// BASE_ADR at top of memory) share one stimulus; a write scoreboard watches the selected one.
module tb_ext_mem_loader;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        longint      cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;

    logic        rdy    [3];
    logic        we     [3];
    logic [31:0] wdat   [3];
    logic [31:0] wadr   [3];
    logic        cpuRst [3];
    logic        bsy    [3];
    logic        dn     [3];
    logic        er     [3];
    logic [8:0]  cnt    [3];
    logic [31:0] chk    [3];

    int          sel = 0;
    int          nChecks = 0;
    int          nFails = 0;
    longint      cycleCnt = 0;
    logic [31:0] nextAdr = '0;
    logic [31:0] expSum = '0;
    bit          acc;
    wr_t         expQ[$];
    wr_t         monE;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    ext_mem_loader u_dutMain (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy[0]), .Ext_MemWrite(we[0]), .Ext_WriteData(wdat[0]),
        .Ext_DataAdr(wadr[0]), .cpu_reset(cpuRst[0]), .busy(bsy[0]), .done(dn[0]),
        .error(er[0]), .word_count(cnt[0]), .checksum(chk[0])
    );

    ext_mem_loader #(.MAX_WORDS(4)) u_dutMax (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy[1]), .Ext_MemWrite(we[1]), .Ext_WriteData(wdat[1]),
        .Ext_DataAdr(wadr[1]), .cpu_reset(cpuRst[1]), .busy(bsy[1]), .done(dn[1]),
        .error(er[1]), .word_count(cnt[1]), .checksum(chk[1])
    );

    ext_mem_loader #(.BASE_ADR(32'hFFFF_FFFC)) u_dutWrap (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy[2]), .Ext_MemWrite(we[2]), .Ext_WriteData(wdat[2]),
        .Ext_DataAdr(wadr[2]), .cpu_reset(cpuRst[2]), .busy(bsy[2]), .done(dn[2]),
        .error(er[2]), .word_count(cnt[2]), .checksum(chk[2])
    );

    // Every write pulse of the selected instance must match the oldest accepted word.
    always @(negedge clk) begin
        if (we[sel]) begin
            nChecks++;
            if (expQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL unexpected_write dut=%0d adr=%h data=%h cyc=%0d", sel, wadr[sel], wdat[sel], cycleCnt);
            end else begin
                monE = expQ.pop_front();
                if (wadr[sel] !== monE.adr || wdat[sel] !== monE.data || cycleCnt !== monE.cyc) begin
                    nFails++;
                    $display("[TB] FAIL write_match dut=%0d got adr=%h data=%h cyc=%0d, want adr=%h data=%h cyc=%0d",
                             sel, wadr[sel], wdat[sel], cycleCnt, monE.adr, monE.data, monE.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        tick; tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic pulseStart;
        nextAdr = (sel == 2) ? 32'hFFFF_FFFC : 32'h0;
        expSum  = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Holds a word on the bus until the selected instance takes it or maxWait cycles pass.
    task automatic sendWord(input logic [31:0] d, input logic l, input int maxWait, output bit accepted);
        accepted = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int i = 0; i < maxWait && !accepted; i++) begin
            if (rdy[sel]) begin
                expQ.push_back('{nextAdr, d, cycleCnt + 1});
                nextAdr  = nextAdr + 32'd4;
                expSum   = expSum + d;
                accepted = 1'b1;
            end
            tick;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int i;
        i = 0;
        while (!dn[sel] && i < 20) begin
            tick;
            i++;
        end
        nChecks++;
        if (dn[sel] !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL %s_done_timeout got done=%b want 1", name, dn[sel]);
        end
    endtask

    task automatic checkDrained(input string name);
        tick; tick;
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL %s_missing_writes got %0d pending want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset;
        sel = 0;
        reset = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            nChecks++;
            if ({rdy[i], we[i], wdat[i], wadr[i], cpuRst[i], bsy[i], dn[i], er[i], cnt[i], chk[i]} !==
                {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0}) begin
                nFails++;
                $display("[TB] FAIL reset_values dut=%0d got rdy=%b we=%b wd=%h wa=%h cpurst=%b busy=%b done=%b err=%b cnt=%0d chk=%h",
                         i, rdy[i], we[i], wdat[i], wadr[i], cpuRst[i], bsy[i], dn[i], er[i], cnt[i], chk[i]);
            end
        end
        start = 1'b0; in_valid = 1'b0; in_data = '0;
        tick;
        reset = 1'b1;
        tick; tick;
        nChecks++;
        if (rdy[0] !== 1'b0 || cpuRst[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL idle_after_reset got rdy=%b cpurst=%b busy=%b want 0 1 0", rdy[0], cpuRst[0], bsy[0]);
        end
    endtask

    task automatic test_basic_load;
        logic [31:0] words [3];
        logic [31:0] expChk;
        words = '{32'h0050_0113, 32'h00C0_0193, 32'h0000_006F};
        applyReset;
        sel = 0;
        pulseStart;
        for (int i = 0; i < 3; i++) begin
            sendWord(words[i], (i == 2), 5, acc);
            nChecks++;
            if (acc !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL basic_accept word=%0d got 0 want 1", i);
            end
        end
        // Release sequence: FLUSH, two RELEASE cycles, then DONE in the fourth cycle.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            nChecks++;
            if (dn[0] !== 1'(k == 4) || cpuRst[0] !== 1'(k != 4) || rdy[0] !== 1'b0 || bsy[0] !== 1'(k != 4)) begin
                nFails++;
                $display("[TB] FAIL basic_release k=%0d got done=%b cpurst=%b rdy=%b busy=%b want done=%b",
                         k, dn[0], cpuRst[0], rdy[0], bsy[0], (k == 4));
            end
            if (k < 4) @(posedge clk);
        end
`ifdef LOADER_CHECKSUM_EN
        expChk = expSum;
`else
        expChk = 32'h0;
`endif
        nChecks++;
        if (cnt[0] !== 9'd3 || chk[0] !== expChk || er[0] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL basic_status got cnt=%0d chk=%h err=%b want 3 %h 0", cnt[0], chk[0], er[0], expChk);
        end
        checkDrained("basic");
    endtask

    task automatic test_gaps;
        applyReset;
        sel = 0;
        pulseStart;
        sendWord(32'hAAAA_0001, 1'b0, 5, acc);
        tick; tick;
        sendWord(32'hAAAA_0002, 1'b1, 5, acc);
        waitDone("gaps");
        nChecks++;
        if (cnt[0] !== 9'd2) begin
            nFails++;
            $display("[TB] FAIL gaps_count got %0d want 2", cnt[0]);
        end
        checkDrained("gaps");
    endtask

    task automatic test_back_to_back;
        // Continues from the DONE state left by test_gaps: restart without reset.
        sel = 0;
        pulseStart;
        nChecks++;
        if (dn[0] !== 1'b0 || cpuRst[0] !== 1'b1 || bsy[0] !== 1'b1 || cnt[0] !== 9'd0) begin
            nFails++;
            $display("[TB] FAIL restart_state got done=%b cpurst=%b busy=%b cnt=%0d want 0 1 1 0", dn[0], cpuRst[0], bsy[0], cnt[0]);
        end
        sendWord(32'h1234_5678, 1'b0, 5, acc);
        start = 1'b1;
        tick;
        start = 1'b0;
        sendWord(32'h9ABC_DEF0, 1'b1, 5, acc);
        waitDone("b2b");
        nChecks++;
        if (cnt[0] !== 9'd2) begin
            nFails++;
            $display("[TB] FAIL busy_start_ignored got cnt=%0d want 2", cnt[0]);
        end
        checkDrained("b2b");
    endtask

    task automatic test_max_words;
        applyReset;
        sel = 1;
        pulseStart;
        for (int i = 0; i < 5; i++) begin
            sendWord(32'hC000_0000 + 32'(i), 1'b0, (i < 4) ? 5 : 3, acc);
            nChecks++;
            if (acc !== 1'(i < 4)) begin
                nFails++;
                $display("[TB] FAIL max_accept word=%0d got %b want %b", i, acc, (i < 4));
            end
        end
        nChecks++;
        if (er[1] !== 1'b1 || cpuRst[1] !== 1'b1 || dn[1] !== 1'b0 || bsy[1] !== 1'b0 || cnt[1] !== 9'd4 || rdy[1] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL max_error got err=%b cpurst=%b done=%b busy=%b cnt=%0d rdy=%b want 1 1 0 0 4 0",
                     er[1], cpuRst[1], dn[1], bsy[1], cnt[1], rdy[1]);
        end
        checkDrained("max");
    endtask

    task automatic test_wrap;
        applyReset;
        sel = 2;
        pulseStart;
        sendWord(32'h0BAD_F00D, 1'b0, 5, acc);
        sendWord(32'h0000_BEEF, 1'b1, 5, acc);
        waitDone("wrap");
        nChecks++;
        if (er[2] !== 1'b0 || cnt[2] !== 9'd2) begin
            nFails++;
            $display("[TB] FAIL wrap_status got err=%b cnt=%0d want 0 2", er[2], cnt[2]);
        end
        checkDrained("wrap");
    endtask

    task automatic test_checksum;
        logic [31:0] expChk;
        applyReset;
        sel = 0;
        pulseStart;
        sendWord(32'hFFFF_FFFF, 1'b0, 5, acc);
        sendWord(32'h0000_0002, 1'b1, 5, acc);
        waitDone("chk");
`ifdef LOADER_CHECKSUM_EN
        expChk = 32'h0000_0001;
`else
        expChk = 32'h0000_0000;
`endif
        tick; tick;
        nChecks++;
        if (chk[0] !== expChk) begin
            nFails++;
            $display("[TB] FAIL checksum got %h want %h", chk[0], expChk);
        end
        checkDrained("chk");
    endtask

    task automatic test_reset_mid_load;
        applyReset;
        sel = 0;
        pulseStart;
        sendWord(32'h5555_0001, 1'b0, 5, acc);
        in_valid = 1'b1; in_data = 32'h5555_0002;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        nChecks++;
        if (rdy[0] !== 1'b0 || cpuRst[0] !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL async_abort got rdy=%b cpurst=%b want 0 1", rdy[0], cpuRst[0]);
        end
        @(posedge clk);
        @(negedge clk);
        nChecks++;
        if ({we[0], wdat[0], wadr[0], cpuRst[0], bsy[0], dn[0], er[0], cnt[0], chk[0]} !==
            {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0}) begin
            nFails++;
            $display("[TB] FAIL abort_values got we=%b wd=%h wa=%h cpurst=%b busy=%b done=%b err=%b cnt=%0d chk=%h",
                     we[0], wdat[0], wadr[0], cpuRst[0], bsy[0], dn[0], er[0], cnt[0], chk[0]);
        end
        in_valid = 1'b0;
        tick;
        reset = 1'b1;
        checkDrained("abort");
    endtask

    initial begin
        test_reset;
        test_basic_load;
        test_gaps;
        test_back_to_back;
        test_max_words;
        test_wrap;
        test_checksum;
        test_reset_mid_load;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
